// File: rtl/latch_bank_write_sequencer.sv
// Round-robin write sequencer for a shared bank of transparent latches.
// Each write runs setup / open / hold so lat_d is stable around every one-hot enable pulse.
module latch_bank_write_sequencer #(
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned DW          = 8,
  parameter int unsigned OPEN_CYCLES = 2,
  localparam int unsigned AW         = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_a,
  input  logic [AW-1:0]      addr_a,
  input  logic [DW-1:0]      data_a,
  output logic               ack_a,
  input  logic               req_b,
  input  logic [AW-1:0]      addr_b,
  input  logic [DW-1:0]      data_b,
  output logic               ack_b,
  output logic [ENTRIES-1:0] lat_en,
  output logic [DW-1:0]      lat_d,
  output logic               busy,
  output logic               grant_b,
  output logic               err
);

  localparam int unsigned CW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic                last_b;
  logic [AW-1:0]       cap_addr;
  logic [CW-1:0]       cnt;
  logic                pick_b;
  logic                addr_oor;
  logic [ENTRIES-1:0]  dec;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pick_b   = req_b && (!req_a || !last_b);
  assign addr_oor = 32'(cap_addr) >= ENTRIES;

  // An out-of-range address matches no entry, so the decode stays all-zero.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (cap_addr == AW'(i)) dec[i] = 1'b1;
    end
  end

  // lat_d is loaded on the grant edge so it is already stable for the whole SETUP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_en   <= '0;
      lat_d    <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      busy     <= 1'b0;
      grant_b  <= 1'b0;
      err      <= 1'b0;
      last_b   <= 1'b1;
      cap_addr <= '0;
      cnt      <= '0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            grant_b  <= pick_b;
            cap_addr <= pick_b ? addr_b : addr_a;
            lat_d    <= pick_b ? data_b : data_a;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          lat_en <= dec;
          cnt    <= CW'(OPEN_CYCLES - 1);
          state  <= OPEN;
        end
        OPEN: begin
          if (cnt == '0) begin
            lat_en <= '0;
            ack_a  <= !grant_b;
            ack_b  <= grant_b;
            err    <= addr_oor;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          last_b <= grant_b;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_sequencer.sv
// Bench for latch_bank_write_sequencer: a 4-entry and a 3-entry instance share stimulus,
// both checked every cycle against a latency-based transaction model plus directed literals.
module tb_latch_bank_write_sequencer;

  localparam int unsigned OC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [1:0] addr_a = '0, addr_b = '0;
  logic [7:0] data_a = '0, data_b = '0;

  logic       ack_a4, ack_b4, busy4, grant_b4, err4;
  logic [3:0] lat_en4;
  logic [7:0] lat_d4;
  logic       ack_a3, ack_b3, busy3, grant_b3, err3;
  logic [2:0] lat_en3;
  logic [7:0] lat_d3;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  latch_bank_write_sequencer #(.ENTRIES(4), .DW(8), .OPEN_CYCLES(OC)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a4),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b4),
    .lat_en(lat_en4), .lat_d(lat_d4), .busy(busy4), .grant_b(grant_b4), .err(err4)
  );

  latch_bank_write_sequencer #(.ENTRIES(3), .DW(8), .OPEN_CYCLES(OC)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a3),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b3),
    .lat_en(lat_en3), .lat_d(lat_d3), .busy(busy3), .grant_b(grant_b3), .err(err3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase counts cycles since the grant edge (0 = idle); all outputs follow from it.
  int unsigned m_phase = 0;
  logic        m_owner_b = 1'b0;
  logic        m_last_b = 1'b1;
  logic [1:0]  m_addr = '0;
  logic [7:0]  m_latd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_owner_b = 1'b0; m_last_b = 1'b1; m_latd = '0; m_addr = '0;
    end else if (m_phase == 0) begin
      if (req_a || req_b) begin
        m_owner_b = req_b && !(req_a && m_last_b);
        m_addr    = m_owner_b ? addr_b : addr_a;
        m_latd    = m_owner_b ? data_b : data_a;
        m_phase   = 1;
      end
    end else if (m_phase == OC + 2) begin
      m_phase  = 0;
      m_last_b = m_owner_b;
    end else begin
      m_phase++;
    end
  end

  int unsigned zero_run = 0;
  bit          seen_pulse = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      logic       open_w, ack_w;
      logic [3:0] e4;
      logic [2:0] e3;
      open_w = (m_phase >= 2) && (m_phase <= OC + 1);
      ack_w  = (m_phase == OC + 2);
      e4 = open_w ? (4'b0001 << m_addr) : 4'b0000;
      e3 = (open_w && m_addr < 2'd3) ? (3'b001 << m_addr) : 3'b000;
      chk("lat_en4", lat_en4, e4);
      chk("lat_d4", lat_d4, m_latd);
      chk("busy4", busy4, m_phase != 0);
      chk("grant_b4", grant_b4, m_owner_b);
      chk("ack_a4", ack_a4, ack_w && !m_owner_b);
      chk("ack_b4", ack_b4, ack_w && m_owner_b);
      chk("err4", err4, 1'b0);
      chk("lat_en3", lat_en3, e3);
      chk("lat_d3", lat_d3, m_latd);
      chk("busy3", busy3, m_phase != 0);
      chk("grant_b3", grant_b3, m_owner_b);
      chk("ack_a3", ack_a3, ack_w && !m_owner_b);
      chk("ack_b3", ack_b3, ack_w && m_owner_b);
      chk("err3", err3, ack_w && m_addr == 2'd3);
      chk("onehot4", $countones(lat_en4) <= 1, 1'b1);
      if (!rst_n) begin
        seen_pulse = 1'b0;
        zero_run   = 0;
      end else if (lat_en4 == '0) begin
        zero_run++;
      end else begin
        if (seen_pulse && zero_run != 0) chk("gap4", zero_run >= 3, 1'b1);
        seen_pulse = 1'b1;
        zero_run   = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    step(1);
    #2 rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    step(2);
    run = 1'b1;
    chk("rst_lat_en", lat_en4, 4'h0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_grant", grant_b4, 1'b0);
    chk("rst_lat_d", lat_d4, 8'h00);
    chk("rst_ack", {ack_a4, ack_b4, err4}, 3'b000);
    step(1);
    rst_n = 1'b1;

    // single write
    req_a = 1'b1; addr_a = 2'd2; data_a = 8'hA5;
    step(1);
    chk("t1_setup_d", lat_d4, 8'hA5);
    chk("t1_setup_en", lat_en4, 4'h0);
    chk("t1_busy", busy4, 1'b1);
    step(1); chk("t1_open1", lat_en4, 4'b0100);
    step(1); chk("t1_open2", lat_en4, 4'b0100);
    step(1); chk("t1_ack", {ack_a4, lat_en4}, {1'b1, 4'h0});
    req_a = 1'b0;
    step(1); chk("t1_idle", {busy4, ack_a4}, 2'b00);
    step(2);

    // simultaneous requests, held: A, B, A
    do_reset();
    req_a = 1'b1; addr_a = 2'd0; data_a = 8'h11;
    req_b = 1'b1; addr_b = 2'd3; data_b = 8'h22;
    step(2);
    chk("t2_a_en", lat_en4, 4'b0001);
    chk("t2_a_d", lat_d4, 8'h11);
    chk("t2_a_gnt", grant_b4, 1'b0);
    step(5);
    chk("t2_b_en", lat_en4, 4'b1000);
    chk("t2_b_d", lat_d4, 8'h22);
    chk("t2_b_gnt", grant_b4, 1'b1);
    chk("t2_b_en3", lat_en3, 3'b000);
    step(2);
    chk("t2_b_ack", ack_b4, 1'b1);
    chk("t2_b_err3", {ack_b3, err3}, 2'b11);
    step(3);
    chk("t2_a2_en", lat_en4, 4'b0001);
    chk("t2_a2_d", lat_d4, 8'h11);
    step(2);
    chk("t2_a2_ack", ack_a4, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    step(3);

    // one-cycle req_b pulse, address changed during OPEN
    req_b = 1'b1; addr_b = 2'd1; data_b = 8'h5A;
    step(1); req_b = 1'b0;
    step(1);
    chk("t3_open", lat_en4, 4'b0010);
    addr_b = 2'd2; data_b = 8'hFF;
    step(1); chk("t3_open2", {lat_en4, lat_d4}, {4'b0010, 8'h5A});
    step(1); chk("t3_ack", ack_b4, 1'b1);
    step(1); chk("t3_idle1", busy4, 1'b0);
    step(1); chk("t3_idle2", busy4, 1'b0);

    // out-of-range address on the 3-entry bank
    req_a = 1'b1; addr_a = 2'd3; data_a = 8'h77;
    step(1); chk("t4_setup_d3", lat_d3, 8'h77);
    step(1);
    chk("t4_en3", lat_en3, 3'b000);
    chk("t4_en4", lat_en4, 4'b1000);
    step(1); chk("t4_en3b", lat_en3, 3'b000);
    step(1);
    chk("t4_ack_err3", {ack_a3, err3}, 2'b11);
    chk("t4_err4", {ack_a4, err4}, 2'b10);
    req_a = 1'b0;
    step(1); chk("t4_idle3", busy3, 1'b0);
    step(2);

    // reset during OPEN, then retry
    req_a = 1'b1; addr_a = 2'd1; data_a = 8'h99;
    step(2);
    chk("t5_open", lat_en4, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_en", lat_en4, 4'h0);
    chk("t5_async_busy", busy4, 1'b0);
    chk("t5_async_ack", {ack_a4, ack_b4}, 2'b00);
    step(1);
    #2 rst_n = 1'b1;
    step(1); chk("t5_retry_setup", {busy4, lat_d4}, {1'b1, 8'h99});
    step(1); chk("t5_retry_open", lat_en4, 4'b0010);
    step(2); chk("t5_retry_ack", ack_a4, 1'b1);
    req_a = 1'b0;
    step(3);

    // back-to-back with held req_a
    req_a = 1'b1; addr_a = 2'd0; data_a = 8'hC3;
    step(1); chk("t6_setup1", lat_d4, 8'hC3);
    step(3); chk("t6_ack1", ack_a4, 1'b1);
    data_a = 8'h3C;
    step(1); chk("t6_idle_d", {busy4, lat_d4}, {1'b0, 8'hC3});
    step(1); chk("t6_setup2", {busy4, lat_en4, lat_d4}, {1'b1, 4'h0, 8'h3C});
    step(3); chk("t6_ack2", ack_a4, 1'b1);
    req_a = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_sequencer.md
Name: latch_bank_write_sequencer

Overview:
- Shares one bank of transparent D-latches between two requesters, A and B.
- Arbitrates between them round-robin.
- Sequences each write as setup, open, hold so the data is stable around every enable pulse and at most one latch is open at a time.
- Sits between user logic and the latch bank; the latch bank itself is outside this block.

Parameters:
ENTRIES, 4, number of latches in the bank; one enable bit per entry; must be >= 2
DW, 8, data width written to each latch
OPEN_CYCLES, 2, number of clock cycles each latch enable is held high; must be >= 1
AW (localparam), clog2(ENTRIES), address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
req_a  input  1  requester A write request, level signal
addr_a  input  AW  requester A target entry
data_a  input  DW  requester A write data
ack_a  output  1  requester A completion pulse, one cycle
req_b  input  1  requester B write request, level signal
addr_b  input  AW  requester B target entry
data_b  input  DW  requester B write data
ack_b  output  1  requester B completion pulse, one cycle
lat_en  output  ENTRIES  one-hot latch enables to the bank
lat_d  output  DW  data bus to the bank
busy  output  1  high while a write is in progress (not IDLE)
grant_b  output  1  current owner: 0 = A, 1 = B
err  output  1  pulses with ack when the address is out of range

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - lat_en, lat_d, ack_a, ack_b, busy, grant_b and err are all 0.
  - last_served = B, so A wins the first tie.
- All outputs are registered. lat_en must never glitch and never has more than one bit high.
- States and transitions:
  - IDLE:
    - If req_a or req_b is sampled high, arbitrate and go to SETUP.
    - Capture the winner's addr and data into internal registers. Set grant_b and busy=1.
    - Single request: that requester wins. Both requesting: the requester other than last_served wins.
    - If neither requests, stay in IDLE.
  - SETUP (1 cycle): lat_d = captured data, lat_en = 0. Go to OPEN.
  - OPEN (OPEN_CYCLES cycles):
    - lat_en[captured addr] = 1 and lat_d stays stable.
    - A down-counter tracks the remaining cycles. Go to HOLD when it expires.
  - HOLD (1 cycle):
    - lat_en = 0 and lat_d stays stable.
    - The granted requester's ack is high for this cycle only.
    - err = 1 in this cycle if the address was out of range.
    - last_served is updated. Go to IDLE; busy drops on entry to IDLE.
- Latency: req sampled high at edge k (in IDLE):
  - SETUP at k+1.
  - lat_en high for cycles k+2 .. k+1+OPEN_CYCLES.
  - ack at k+2+OPEN_CYCLES.
  - IDLE at k+3+OPEN_CYCLES.
- Handshake:
  - The requester holds req until its ack.
  - Address and data are captured at grant; later changes to addr or data are ignored.
  - If req drops mid-transaction, the write still completes and ack still pulses.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
- Spacing:
  - At least one IDLE cycle plus one SETUP cycle separate transactions.
  - Between any two enable pulses, lat_en is all-zero for at least 3 cycles (HOLD, IDLE, SETUP).
- Out-of-range address (addr >= ENTRIES, possible only when ENTRIES is not a power of 2):
  - No lat_en bit is asserted.
  - The sequence timing is unchanged; ack and err pulse together.
- lat_d keeps the last written value in IDLE; it changes only in SETUP.
- Reset mid-transaction: all outputs clear immediately and no ack is issued. Requesters must re-request.
- Requests arriving in any state other than IDLE wait. There is no queueing beyond the level req.

Test Plan:
- Single write, ENTRIES=4, DW=8, OPEN_CYCLES=2: req_a=1, addr_a=2, data_a=0xA5 → SETUP next cycle with lat_d=0xA5; lat_en=4'b0100 for exactly 2 cycles; ack_a for 1 cycle, 4 cycles after grant; busy low afterwards.
- Simultaneous requests, held: req_a and req_b both held high, with addr_a=0, data_a=0x11 and addr_b=3, data_b=0x22 → A is served first (lat_en=0001, lat_d=0x11), then B (lat_en=1000, lat_d=0x22), then A again. Grants alternate; enables never overlap; at least 3 zero cycles between enable pulses.
- Mid-transaction changes: req_b pulsed for 1 cycle, then addr_b changed during OPEN → write targets the captured address; ack_b still pulses; no second transaction starts.
- Out-of-range address: ENTRIES=3, addr_a=3 → lat_en stays 000 throughout; ack_a and err high in the same cycle; total timing identical to a valid write.
- Reset during OPEN: rst_n asserted with lat_en=0010 → lat_en, busy and ack clear immediately (asynchronously). After release, a retried req_a is granted and completes normally.
- Back-to-back: req_a held through ack with new data 0x3C → second SETUP starts exactly 2 cycles after the first ack; lat_d changes only in SETUP.
